// File: rtl/vga_text_console_pkg.sv
// Shared constants, state encoding and address helper for the text console.
// Optional feature macro: CONSOLE_SCROLL_EN (adds the VRAM scroll states).
package console_pkg;

  localparam int unsigned COLS         = 80;
  localparam int unsigned ROWS         = 25;
  localparam int unsigned CELLS        = 2000;
  localparam int unsigned SCROLL_CELLS = 1920;

  localparam logic [11:0] ATTR_BASE = 12'h800;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    WCH,
    WAT,
    CLR
`ifdef CONSOLE_SCROLL_EN
    ,
    SC_RD,
    SC_CAP,
    SC_WR,
    SC_FILL
`endif
  } state_t;

  // row*80 + col, built from shifts so no multiplier is needed
  function automatic logic [10:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    return {row, 6'b000000} + {2'b00, row, 4'b0000} + {4'b0000, col};
  endfunction

endpackage

// File: rtl/vga_text_console_if.sv
// Byte-stream handshake plus VRAM system-port bus of the text console.
// master: the console (drives VRAM port and char_ready).
// slave : the surrounding byte source and VRAM.
interface vga_text_console_if;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [7:0]  attr_in;
  logic [11:0] vram_addr;
  logic [7:0]  vram_din;
  logic        vram_we;
  logic [7:0]  vram_dout;

  modport master (
    input  char_in, char_valid, attr_in, vram_dout,
    output char_ready, vram_addr, vram_din, vram_we
  );

  modport slave (
    output char_in, char_valid, attr_in, vram_dout,
    input  char_ready, vram_addr, vram_din, vram_we
  );
endinterface

// File: rtl/vga_text_console.sv
// Character-stream terminal controller owning the 80x25 text VRAM system port.
// Handles CR, LF, BS, FF and printable bytes, maintains the cursor.
// Optional feature macro: CONSOLE_SCROLL_EN -- LF on the last row scrolls the
// screen by copying VRAM through the same port; otherwise the cursor wraps to row 0.
module vga_text_console
  import console_pkg::*;
(
  input  logic                      vclk,
  input  logic                      rst_n,
  vga_text_console_if.master        bus,
  output logic [6:0]                cur_col,
  output logic [4:0]                cur_row,
  output logic                      busy
);

  localparam logic [6:0]  COL_LAST  = 7'(COLS - 1);
  localparam logic [4:0]  ROW_LAST  = 5'(ROWS - 1);
  localparam logic [10:0] CELL_LAST = 11'(CELLS - 1);
`ifdef CONSOLE_SCROLL_EN
  localparam logic [10:0] COPY_LAST = 11'(SCROLL_CELLS - 1);
  localparam logic [10:0] FILL_LAST = 11'(COLS - 1);
`endif

  state_t      state_q, state_n;
  logic [6:0]  col_q, col_n;
  logic [4:0]  row_q, row_n;
  logic [10:0] idx_q, idx_n;
  logic        plane_q, plane_n;
  logic [7:0]  attr_q, attr_n;
  logic [11:0] addr_q, addr_n;
  logic [7:0]  din_q, din_n;
  logic        we_q, we_n;
  logic        busy_q, busy_n;
  logic        do_lf;

`ifndef CONSOLE_SCROLL_EN
  logic unused_dout;
  assign unused_dout = ^bus.vram_dout;
`endif

  assign bus.char_ready = (state_q == IDLE);
  assign bus.vram_addr  = addr_q;
  assign bus.vram_din   = din_q;
  assign bus.vram_we    = we_q;
  assign cur_col        = col_q;
  assign cur_row        = row_q;
  assign busy           = busy_q;

  // Next-state and next-output decode; every VRAM output is registered from here.
  always_comb begin
    state_n = state_q;
    col_n   = col_q;
    row_n   = row_q;
    idx_n   = idx_q;
    plane_n = plane_q;
    attr_n  = attr_q;
    addr_n  = addr_q;
    din_n   = din_q;
    we_n    = 1'b0;
    busy_n  = busy_q;
    do_lf   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.char_valid) begin
          attr_n = bus.attr_in;
          case (bus.char_in)
            CH_CR: col_n = '0;
            CH_LF: do_lf = 1'b1;
            CH_BS: begin
              if (col_q != '0) col_n = col_q - 7'd1;
            end
            CH_FF: begin
              state_n = CLR;
              idx_n   = '0;
              plane_n = 1'b0;
              addr_n  = '0;
              din_n   = CH_SPACE;
              we_n    = 1'b1;
              busy_n  = 1'b1;
            end
            default: begin
              state_n = WCH;
              addr_n  = {1'b0, cell_addr(row_q, col_q)};
              din_n   = bus.char_in;
              we_n    = 1'b1;
            end
          endcase
        end
      end

      WCH: begin
        state_n = WAT;
        addr_n  = addr_q | ATTR_BASE;
        din_n   = attr_q;
        we_n    = 1'b1;
      end

      WAT: begin
        state_n = IDLE;
        if (col_q == COL_LAST) begin
          col_n = '0;
          do_lf = 1'b1;
        end else begin
          col_n = col_q + 7'd1;
        end
      end

      // Char plane first, then attribute plane, sharing idx/plane.
      CLR: begin
        if (idx_q == CELL_LAST) begin
          if (!plane_q) begin
            plane_n = 1'b1;
            idx_n   = '0;
            addr_n  = ATTR_BASE;
            din_n   = attr_q;
            we_n    = 1'b1;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
            col_n   = '0;
            row_n   = '0;
          end
        end else begin
          idx_n  = idx_q + 11'd1;
          addr_n = {plane_q, idx_q + 11'd1};
          we_n   = 1'b1;
        end
      end

`ifdef CONSOLE_SCROLL_EN
      SC_RD: state_n = SC_CAP;

      // vram_din doubles as the capture register for the copied byte.
      SC_CAP: begin
        state_n = SC_WR;
        addr_n  = {plane_q, idx_q};
        din_n   = bus.vram_dout;
        we_n    = 1'b1;
      end

      SC_WR: begin
        if (idx_q == COPY_LAST) begin
          state_n = SC_FILL;
          idx_n   = '0;
          addr_n  = {plane_q, 11'(SCROLL_CELLS)};
          din_n   = plane_q ? attr_q : CH_SPACE;
          we_n    = 1'b1;
        end else begin
          state_n = SC_RD;
          idx_n   = idx_q + 11'd1;
          addr_n  = {plane_q, idx_q + 11'(COLS + 1)};
        end
      end

      SC_FILL: begin
        if (idx_q == FILL_LAST) begin
          if (!plane_q) begin
            state_n = SC_RD;
            plane_n = 1'b1;
            idx_n   = '0;
            addr_n  = {1'b1, 11'(COLS)};
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
            col_n   = '0;
            row_n   = ROW_LAST;
          end
        end else begin
          idx_n  = idx_q + 11'd1;
          addr_n = addr_q + 12'd1;
          we_n   = 1'b1;
        end
      end
`endif

      default: state_n = IDLE;
    endcase

    // Line feed shared by explicit LF and wrap after column 79.
    if (do_lf) begin
      if (row_q != ROW_LAST) begin
        row_n = row_q + 5'd1;
      end else begin
`ifdef CONSOLE_SCROLL_EN
        state_n = SC_RD;
        idx_n   = '0;
        plane_n = 1'b0;
        addr_n  = 12'(COLS);
        we_n    = 1'b0;
        busy_n  = 1'b1;
`else
        row_n   = '0;
`endif
      end
    end
  end

  // State, cursor, sweep counter and registered VRAM outputs.
  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      plane_q <= 1'b0;
      attr_q  <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      col_q   <= col_n;
      row_q   <= row_n;
      idx_q   <= idx_n;
      plane_q <= plane_n;
      attr_q  <= attr_n;
      addr_q  <= addr_n;
      din_q   <= din_n;
      we_q    <= we_n;
      busy_q  <= busy_n;
    end
  end

endmodule
